// File: rtl/pq_seq_pkg.sv
// Shared types for the priority-queue command sequencer: opcodes, FSM states,
// the buffered command record and small helpers used by the datapath.
package pq_seq_pkg;

    localparam int CMD_DATA_W = 16;

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_PUSH    = 2'b01,
        OP_POP     = 2'b10,
        OP_REPLACE = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_SETTLE,
        ST_RESP
    } state_e;

    typedef struct packed {
        op_e                   op;
        logic [CMD_DATA_W-1:0] data;
    } cmd_t;

    // Key 0 is the queue's empty-slot marker, so it can never be stored.
    function automatic logic is_rejected(input cmd_t cmd, input logic pq_full, input logic pq_empty);
        return ((cmd.op == OP_PUSH) && pq_full)
            || (((cmd.op == OP_PUSH) || (cmd.op == OP_REPLACE)) && (cmd.data == '0))
            || ((cmd.op == OP_POP) && pq_empty);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/pq_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so full and
// empty are distinguished without a separate occupancy counter.
module pq_cmd_fifo
    import pq_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic i_CLK,
    input  logic i_RST,
    input  logic i_wr_en,
    input  cmd_t i_wr_cmd,
    input  logic i_rd_en,
    output cmd_t o_rd_cmd,
    output logic o_full,
    output logic o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    cmd_t        r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_wr;
    logic        w_rd;

    assign w_wr = i_wr_en && !o_full;
    assign w_rd = i_rd_en && !o_empty;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge i_CLK) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_cmd;
    end

    assign o_empty  = (r_wr_ptr == r_rd_ptr);
    assign o_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_rd_cmd = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/pq_cmd_sequencer.sv
// Command front-end for the register-array priority queue: buffers commands,
// issues one strobe per command, waits for the sort network, returns a response.
// Optional counters: define PQ_CMD_SEQUENCER_STATS_EN.
module pq_cmd_sequencer
    import pq_seq_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int QUEUE_SIZE    = 4,
    parameter int CMD_DEPTH     = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [1:0]            i_cmd_op,
    input  logic [DATA_WIDTH-1:0] i_cmd_data,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic                  o_rsp_err,
    output logic                  o_pq_wrt,
    output logic                  o_pq_read,
    output logic [DATA_WIDTH-1:0] o_pq_data,
    input  logic                  i_pq_full,
    input  logic                  i_pq_empty,
    input  logic [DATA_WIDTH-1:0] i_pq_data
`ifdef PQ_CMD_SEQUENCER_STATS_EN
    ,
    output logic [15:0]           o_stat_push,
    output logic [15:0]           o_stat_pop,
    output logic [15:0]           o_stat_err
`endif
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    if (DATA_WIDTH != CMD_DATA_W) begin : g_bad_width
        $error("DATA_WIDTH must equal pq_seq_pkg::CMD_DATA_W");
    end
    if ((CMD_DEPTH < 2) || ((CMD_DEPTH & (CMD_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("CMD_DEPTH must be a power of 2 and at least 2");
    end
    if ((SETTLE_CYCLES < 1) || (QUEUE_SIZE < 1)) begin : g_bad_cfg
        $error("SETTLE_CYCLES and QUEUE_SIZE must be at least 1");
    end

    state_e                r_state;
    state_e                w_next_state;
    cmd_t                  r_cmd;
    cmd_t                  w_fifo_in;
    cmd_t                  w_fifo_head;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_fifo_wr;
    logic                  w_fifo_rd;
    logic                  w_reject;
    logic                  w_issue;
    logic [CNT_W-1:0]      r_settle_cnt;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_err;
    logic                  r_pq_wrt;
    logic                  r_pq_read;
    logic [DATA_WIDTH-1:0] r_pq_data;

    // Ready is forced low while reset is held so nothing is taken before the pointers clear.
    assign o_cmd_ready = !w_fifo_full && !i_RST;
    assign w_fifo_in   = '{op: op_e'(i_cmd_op), data: i_cmd_data};
    assign w_fifo_wr   = i_cmd_valid && o_cmd_ready && (op_e'(i_cmd_op) != OP_NOP);
    assign w_fifo_rd   = (r_state == ST_IDLE) && !w_fifo_empty;

    pq_cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .i_CLK    (i_CLK),
        .i_RST    (i_RST),
        .i_wr_en  (w_fifo_wr),
        .i_wr_cmd (w_fifo_in),
        .i_rd_en  (w_fifo_rd),
        .o_rd_cmd (w_fifo_head),
        .o_full   (w_fifo_full),
        .o_empty  (w_fifo_empty)
    );

    // NOTE: every combinational output gets its default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_reject     = is_rejected(r_cmd, i_pq_full, i_pq_empty);
        w_issue      = 1'b0;
        unique case (r_state)
            ST_IDLE:   if (!w_fifo_empty) w_next_state = ST_CHECK;
            ST_CHECK: begin
                w_issue      = !w_reject;
                w_next_state = w_reject ? ST_RESP : ST_ISSUE;
            end
            ST_ISSUE:  w_next_state = ST_SETTLE;
            ST_SETTLE: if (r_settle_cnt == CNT_W'(1)) w_next_state = ST_RESP;
            ST_RESP:   if (i_rsp_ready) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Strobes are loaded on the CHECK->ISSUE edge so they are high exactly during ISSUE.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_state      <= ST_IDLE;
            r_cmd        <= '0;
            r_settle_cnt <= '0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
            r_pq_wrt     <= 1'b0;
            r_pq_read    <= 1'b0;
            r_pq_data    <= '0;
        end else begin
            r_state   <= w_next_state;
            r_pq_wrt  <= w_issue && ((r_cmd.op == OP_PUSH) || (r_cmd.op == OP_REPLACE));
            r_pq_read <= w_issue && ((r_cmd.op == OP_POP) || (r_cmd.op == OP_REPLACE));
            r_pq_data <= w_issue ? r_cmd.data : '0;
            if (w_fifo_rd) r_cmd <= w_fifo_head;
            unique case (r_state)
                ST_CHECK: begin
                    if (w_reject) begin
                        r_rsp_err  <= 1'b1;
                        r_rsp_data <= '0;
                    end
                end
                ST_ISSUE: begin
                    r_rsp_data   <= (r_cmd.op == OP_PUSH) ? '0 : i_pq_data;
                    r_rsp_err    <= 1'b0;
                    r_settle_cnt <= CNT_W'(SETTLE_CYCLES);
                end
                ST_SETTLE: r_settle_cnt <= r_settle_cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

`ifdef PQ_CMD_SEQUENCER_STATS_EN
    logic [15:0] r_stat_push;
    logic [15:0] r_stat_pop;
    logic [15:0] r_stat_err;

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_stat_push <= '0;
            r_stat_pop  <= '0;
            r_stat_err  <= '0;
        end else begin
            if ((r_state == ST_ISSUE) && (r_cmd.op == OP_PUSH)) r_stat_push <= sat_inc(r_stat_push);
            if ((r_state == ST_ISSUE) && (r_cmd.op != OP_PUSH)) r_stat_pop <= sat_inc(r_stat_pop);
            if ((r_state == ST_CHECK) && w_reject) r_stat_err <= sat_inc(r_stat_err);
        end
    end

    assign o_stat_push = r_stat_push;
    assign o_stat_pop  = r_stat_pop;
    assign o_stat_err  = r_stat_err;
`endif

    assign o_rsp_valid = (r_state == ST_RESP);
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_err   = r_rsp_err;
    assign o_pq_wrt    = r_pq_wrt;
    assign o_pq_read   = r_pq_read;
    assign o_pq_data   = r_pq_data;

endmodule

// File: tb/tb_pq_cmd_sequencer.sv
// Directed bench for pq_cmd_sequencer: a behavioural max-first queue stands in
// for the downstream sort network; a vector table plus hand sequences check responses.
module tb_pq_cmd_sequencer;

    localparam int DW = 16;
    localparam int QS = 4;
    localparam int CD = 4;
    localparam int SC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [DW-1:0] cmd_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          pq_wrt;
    logic          pq_read;
    logic [DW-1:0] pq_wdata;
    logic          pq_full = 1'b0;
    logic          pq_empty = 1'b1;
    logic [DW-1:0] pq_head = '0;
`ifdef PQ_CMD_SEQUENCER_STATS_EN
    logic [15:0]   stat_push;
    logic [15:0]   stat_pop;
    logic [15:0]   stat_err;
`endif

    always #5 clk = ~clk;

    pq_cmd_sequencer #(
        .DATA_WIDTH    (DW),
        .QUEUE_SIZE    (QS),
        .CMD_DEPTH     (CD),
        .SETTLE_CYCLES (SC)
    ) dut (
        .i_CLK       (clk),
        .i_RST       (rst),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_op    (cmd_op),
        .i_cmd_data  (cmd_data),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_rsp_err   (rsp_err),
        .o_pq_wrt    (pq_wrt),
        .o_pq_read   (pq_read),
        .o_pq_data   (pq_wdata),
        .i_pq_full   (pq_full),
        .i_pq_empty  (pq_empty),
        .i_pq_data   (pq_head)
`ifdef PQ_CMD_SEQUENCER_STATS_EN
        ,
        .o_stat_push (stat_push),
        .o_stat_pop  (stat_pop),
        .o_stat_err  (stat_err)
`endif
    );

    // Downstream queue stand-in: largest key at the head, reset together with the DUT.
    int q [QS];
    int q_cnt = 0;
    int pos;
    always @(posedge clk) begin
        if (rst) begin
            q_cnt = 0;
        end else begin
            if (pq_read && q_cnt > 0) begin
                for (int i = 0; i < QS - 1; i++) q[i] = q[i+1];
                q_cnt--;
            end
            if (pq_wrt && q_cnt < QS) begin
                pos = q_cnt;
                while (pos > 0 && q[pos-1] < int'(pq_wdata)) begin
                    q[pos] = q[pos-1];
                    pos--;
                end
                q[pos] = int'(pq_wdata);
                q_cnt++;
            end
        end
        pq_full  <= (q_cnt == QS);
        pq_empty <= (q_cnt == 0);
        pq_head  <= (q_cnt > 0) ? DW'(q[0]) : '0;
    end

    // Strobe monitor, sampled mid-cycle.
    int            cyc = 0;
    int            last_strobe = -100;
    int            n_wrt = 0;
    int            n_rd = 0;
    int            n_both = 0;
    int            spacing_bad = 0;
    logic [DW-1:0] last_wdata = '0;
    always @(negedge clk) begin
        cyc++;
        if (pq_wrt || pq_read) begin
            if (cyc - last_strobe < SC + 1) spacing_bad++;
            last_strobe = cyc;
            if (pq_wrt) begin
                n_wrt++;
                last_wdata = pq_wdata;
            end
            if (pq_read) n_rd++;
            if (pq_wrt && pq_read) n_both++;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge after the command was taken.
    task automatic send(input int op, input int d);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_data  = DW'(d);
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accepted", 32'(n < 300), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
    endtask

    task automatic wait_rsp(output logic got, output logic [DW-1:0] d, output logic e);
        int n = 0;
        while (!rsp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        got = rsp_valid;
        d   = rsp_data;
        e   = rsp_err;
        @(negedge clk);
    endtask

    typedef struct {
        int            op;
        int            data;
        logic          exp_err;
        logic [DW-1:0] exp_data;
        int            exp_wrt;
        int            exp_rd;
    } vec_t;

    vec_t          vecs [15];
    int            bp_op [6];
    int            bp_d [6];
    int            bp_exp [6];
    logic          got;
    logic [DW-1:0] d;
    logic          e;
    int            n;

    initial begin
        // op codes: 1 PUSH, 2 POP, 3 REPLACE
        vecs[0]  = '{1, 5, 1'b0, 16'd0, 1, 0};
        vecs[1]  = '{1, 9, 1'b0, 16'd0, 1, 0};
        vecs[2]  = '{2, 0, 1'b0, 16'd9, 0, 1};
        vecs[3]  = '{2, 0, 1'b0, 16'd5, 0, 1};
        vecs[4]  = '{2, 0, 1'b1, 16'd0, 0, 0};
        vecs[5]  = '{1, 0, 1'b1, 16'd0, 0, 0};
        vecs[6]  = '{1, 3, 1'b0, 16'd0, 1, 0};
        vecs[7]  = '{1, 8, 1'b0, 16'd0, 1, 0};
        vecs[8]  = '{3, 4, 1'b0, 16'd8, 1, 1};
        vecs[9]  = '{3, 0, 1'b1, 16'd0, 0, 0};
        vecs[10] = '{1, 7, 1'b0, 16'd0, 1, 0};
        vecs[11] = '{1, 1, 1'b0, 16'd0, 1, 0};
        vecs[12] = '{1, 7, 1'b1, 16'd0, 0, 0};
        vecs[13] = '{3, 2, 1'b0, 16'd7, 1, 1};
        vecs[14] = '{2, 0, 1'b0, 16'd4, 0, 1};
        // Queue holds {3,2,1} when the backpressure sequence starts.
        bp_op  = '{2, 2, 2, 1, 1, 2};
        bp_d   = '{0, 0, 0, 10, 11, 0};
        bp_exp = '{3, 2, 1, 0, 0, 11};

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_err", 32'(rsp_err), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_strobes", {30'd0, pq_wrt, pq_read}, 0);
        check("rst_pq_data", 32'(pq_wdata), 0);
        rst = 1'b0;
        #1;
        check("post_rst_cmd_ready", 32'(cmd_ready), 1);
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            n_wrt  = 0;
            n_rd   = 0;
            n_both = 0;
            send(vecs[i].op, vecs[i].data);
            wait_rsp(got, d, e);
            check($sformatf("v%0d_rsp_seen", i), 32'(got), 1);
            check($sformatf("v%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_data", i), 32'(d), 32'(vecs[i].exp_data));
            check($sformatf("v%0d_wrt_count", i), n_wrt, vecs[i].exp_wrt);
            check($sformatf("v%0d_read_count", i), n_rd, vecs[i].exp_rd);
            check($sformatf("v%0d_both_count", i), n_both, vecs[i].exp_wrt * vecs[i].exp_rd);
            if (vecs[i].exp_wrt != 0)
                check($sformatf("v%0d_pq_data", i), 32'(last_wdata), 32'(vecs[i].data));
        end

        // NOP is taken but produces neither a strobe nor a response.
        n_wrt = 0;
        n_rd  = 0;
        send(0, 55);
        n = 0;
        repeat (15) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        check("nop_no_rsp", n, 0);
        check("nop_no_strobe", n_wrt + n_rd, 0);

        // Backpressure: one in flight plus CMD_DEPTH buffered, then ready drops.
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) send(bp_op[k], bp_d[k]);
        check("bp_ready_low_after_5", 32'(cmd_ready), 0);
        cmd_valid = 1'b1;
        cmd_op    = 2'(bp_op[5]);
        cmd_data  = DW'(bp_d[5]);
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (cmd_ready) n++;
        end
        check("bp_ready_stays_low", n, 0);
        check("bp_rsp_held", 32'(rsp_valid), 1);
        fork
            send(bp_op[5], bp_d[5]);
            begin
                rsp_ready = 1'b1;
                for (int k = 0; k < 6; k++) begin
                    wait_rsp(got, d, e);
                    check($sformatf("bp%0d_rsp_seen", k), 32'(got), 1);
                    check($sformatf("bp%0d_err", k), 32'(e), 0);
                    check($sformatf("bp%0d_data", k), 32'(d), 32'(bp_exp[k]));
                end
            end
        join

        // Reset while the first of two queued commands is settling.
        send(1, 6);
        send(1, 12);
        n = 0;
        while (!pq_wrt && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_saw_issue", 32'(pq_wrt), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_strobes", {30'd0, pq_wrt, pq_read}, 0);
        check("rst_mid_rsp_valid", 32'(rsp_valid), 0);
        check("rst_mid_cmd_ready", 32'(cmd_ready), 0);
        check("rst_mid_rsp_data", 32'(rsp_data), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ready_back", 32'(cmd_ready), 1);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid || pq_wrt) n++;
        end
        check("rst_mid_fifo_flushed", n, 0);
        n_rd = 0;
        send(2, 0);
        wait_rsp(got, d, e);
        check("rst_pop_rsp_seen", 32'(got), 1);
        check("rst_pop_err", 32'(e), 1);
        check("rst_pop_data", 32'(d), 0);
        check("rst_pop_no_read", n_rd, 0);

        check("strobe_spacing_violations", spacing_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
